jttrack_objline: RTL and testbench

Sprite line renderer for Track & Field: the responder side of the object-table scanner's draw/busy handshake. Accepts one sprite-row request at a time and fetches the 16-pixel row from object ROM over the SDRAM slot. Maps each pixel through the 256×4 colour PROM and writes non-transparent pixels into a double-buffered 256-pixel line buffer. Plays the buffer of the previous line out at the pixel clock.

---
 rtl/jttrack_objline.sv | 143 ++++++++++++++
 tb/tb_jttrack_objline.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jttrack_objline.sv
// Sprite line renderer: fetches one 16-pixel sprite row per request, colours it through the
// palette PROM and draws it into one half of a double line buffer while the other plays out.
module jttrack_objline #(
  parameter logic [7:0] HOFFSET = 8'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        hinit_x,
  input  logic        LHBL,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [7:0]  prog_addr,
  input  logic [3:0]  prog_data,
  input  logic        prog_en,
  output logic [13:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} st_e;

  st_e         st_q, st_d;
  logic        busy_q, busy_d, half_q, half_d, hflip_q, hflip_d, vflip_q, vflip_d;
  logic        rom_cs_q, rom_cs_d, wr_sel_q, wr_sel_d;
  logic [2:0]  ix_q, ix_d;
  logic [8:0]  code_q, code_d;
  logic [7:0]  xpos_q, xpos_d;
  logic [3:0]  pal_q, pal_d, ysub_q, ysub_d, pxl_q, pxl_d;
  logic [31:0] pix_q, pix_d;
  logic [13:0] rom_addr_q, rom_addr_d;

  logic [3:0] prom  [256];
  logic [3:0] lbuf0 [256];
  logic [3:0] lbuf1 [256];

  logic [2:0]  nib_idx;
  logic [31:0] pix_sh;
  logic [3:0]  nib, colour, play;
  logic [8:0]  col_x;
  logic [7:0]  wr_addr, pl_addr;
  logic        we, erase;
  logic        unused_hdump;

  assign unused_hdump = hdump[8];
  assign nib_idx = hflip_q ? ~ix_q : ix_q;
  assign pix_sh  = pix_q << {nib_idx, 2'b00};
  assign nib     = pix_sh[31:28];
  assign colour  = prom[{pal_q, nib}];
  // 9-bit column so sprites running past 255 are clipped instead of wrapping
  assign col_x   = {1'b0, xpos_q} + {5'd0, half_q, ix_q};
  assign wr_addr = col_x[7:0] - HOFFSET;
  assign pl_addr = hdump[7:0];
  assign play    = wr_sel_q ? lbuf0[pl_addr] : lbuf1[pl_addr];
  assign erase   = rst_n && pxl_cen && LHBL;

  always_comb begin
    st_d = st_q; busy_d = busy_q; half_d = half_q; hflip_d = hflip_q; vflip_d = vflip_q;
    rom_cs_d = rom_cs_q; wr_sel_d = wr_sel_q; ix_d = ix_q; code_d = code_q;
    xpos_d = xpos_q; pal_d = pal_q; ysub_d = ysub_q; pix_d = pix_q;
    rom_addr_d = rom_addr_q; pxl_d = pxl_q;
    we = 1'b0;
    if (pxl_cen) pxl_d = LHBL ? play : 4'd0;
    if (cen2) begin
      if (hinit_x) begin
        wr_sel_d = ~wr_sel_q;
        st_d     = IDLE;
        busy_d   = 1'b0;
        rom_cs_d = 1'b0;
      end else begin
        case (st_q)
          FETCH: if (rom_ok) begin
            pix_d    = rom_data;
            ix_d     = 3'd0;
            rom_cs_d = 1'b0;
            st_d     = WRITE;
          end
          WRITE: begin
            we   = rst_n && (colour != 4'd0) && !col_x[8];
            ix_d = ix_q + 3'd1;
            if (ix_q == 3'd7) begin
              if (!half_q) begin
                half_d     = 1'b1;
                st_d       = FETCH;
                rom_cs_d   = 1'b1;
                rom_addr_d = {code_q, ysub_q ^ {4{vflip_q}}, ~hflip_q};
              end else begin
                busy_d = 1'b0;
                st_d   = IDLE;
              end
            end
          end
          default: ;
        endcase
      end
      // a line start frees the engine, so a coincident request lands in the new buffer
      if (draw && (!busy_q || hinit_x)) begin
        code_d = code; xpos_d = xpos; pal_d = pal; hflip_d = hflip; vflip_d = vflip;
        ysub_d = ysub; busy_d = 1'b1; half_d = 1'b0; st_d = FETCH; rom_cs_d = 1'b1;
        rom_addr_d = {code, ysub ^ {4{vflip}}, hflip};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE; busy_q <= 1'b0; half_q <= 1'b0; hflip_q <= 1'b0; vflip_q <= 1'b0;
      rom_cs_q <= 1'b0; wr_sel_q <= 1'b0; ix_q <= 3'd0; code_q <= 9'd0; xpos_q <= 8'd0;
      pal_q <= 4'd0; ysub_q <= 4'd0; pix_q <= 32'd0; rom_addr_q <= 14'd0; pxl_q <= 4'd0;
    end else begin
      st_q <= st_d; busy_q <= busy_d; half_q <= half_d; hflip_q <= hflip_d; vflip_q <= vflip_d;
      rom_cs_q <= rom_cs_d; wr_sel_q <= wr_sel_d; ix_q <= ix_d; code_q <= code_d; xpos_q <= xpos_d;
      pal_q <= pal_d; ysub_q <= ysub_d; pix_q <= pix_d; rom_addr_q <= rom_addr_d; pxl_q <= pxl_d;
    end
  end

  always_ff @(posedge clk) if (prog_en) prom[prog_addr] <= prog_data;

  // playback erases behind itself so each buffer is blank for its next draw turn
  always_ff @(posedge clk) begin
    if (we && !wr_sel_q)  lbuf0[wr_addr] <= colour;
    if (erase && wr_sel_q) lbuf0[pl_addr] <= 4'd0;
  end

  always_ff @(posedge clk) begin
    if (we && wr_sel_q)     lbuf1[wr_addr] <= colour;
    if (erase && !wr_sel_q) lbuf1[pl_addr] <= 4'd0;
  end

  assign busy     = busy_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign pxl      = pxl_q;
endmodule

// File: tb/tb_jttrack_objline.sv
// Scoreboard bench for jttrack_objline: expected ROM addresses and playback pixels are queued
// by the stimulus and popped by monitors when the DUT fetches or emits a pixel.
module tb_jttrack_objline;
  logic clk = 1'b0, rst_n, pxl_cen, cen2, hinit_x, LHBL, draw, busy, hflip, vflip, prog_en;
  logic rom_cs, rom_ok;
  logic [8:0] hdump, code;
  logic [7:0] xpos, prog_addr;
  logic [3:0] pal, ysub, prog_data, pxl;
  logic [13:0] rom_addr;
  logic [31:0] rom_data, w0, w1;
  logic [1:0] cnt = 2'd0;

  jttrack_objline dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cen2(cen2), .hinit_x(hinit_x), .LHBL(LHBL),
    .hdump(hdump), .draw(draw), .busy(busy), .code(code), .xpos(xpos), .pal(pal),
    .hflip(hflip), .vflip(vflip), .ysub(ysub), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_en(prog_en), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .rom_ok(rom_ok), .pxl(pxl));

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 2'd1;
  assign cen2     = cnt[0];
  assign pxl_cen  = &cnt;
  assign rom_data = rom_addr[0] ? w1 : w0;

  int errors = 0, checks = 0;
  logic [13:0] aq[$];
  logic [3:0]  pq[$];
  logic [3:0]  prom_m [256];
  logic [3:0]  exp_draw [256];
  logic [3:0]  exp_play [256];
  logic        pchk = 1'b0;
  logic [3:0]  pm_exp;
  logic        pm_none;
  int          pm_h;
  logic [13:0] am_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // fetch monitor: a capture happens at the coming edge when cen2 && rom_cs && rom_ok
  always @(negedge clk) begin
    if (rst_n && cen2 && rom_cs && rom_ok && !hinit_x) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected actual=%0h required=none", rom_addr);
      end else begin
        am_exp = aq.pop_front();
        if (rom_addr !== am_exp) begin
          errors++;
          $display("FAIL rom_addr actual=%0h required=%0h", rom_addr, am_exp);
        end
      end
    end
  end

  // pixel monitor: pxl is compared one edge after the pxl_cen slot that read it
  always @(negedge clk) begin
    if (pchk && pxl_cen) begin
      pm_h = int'(hdump);
      pm_none = (pq.size() == 0);
      pm_exp = pm_none ? 4'd0 : pq.pop_front();
      @(posedge clk); #1;
      checks++;
      if (pm_none || pxl !== pm_exp) begin
        errors++;
        $display("FAIL pxl h=%0d actual=%0h required=%0h", pm_h, pxl, pm_exp);
      end
    end
  end

  task automatic tick2();
    @(negedge clk); while (!cen2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic tick_pxl();
    @(negedge clk); while (!pxl_cen) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic play_line(input bit chk_en);
    for (int h = 0; h < 256; h++) begin
      hdump = 9'(h);
      if (chk_en) pq.push_back(exp_play[h]);
      pchk = chk_en;
      tick_pxl();
    end
    pchk = 1'b0;
  endtask

  task automatic model_swap();
    exp_play = exp_draw;
    for (int i = 0; i < 256; i++) exp_draw[i] = 4'd0;
  endtask

  task automatic swap();
    hinit_x = 1'b1; tick2(); hinit_x = 1'b0;
    model_swap();
  endtask

  task automatic model_draw(input logic [7:0] x0, input logic [3:0] p, input bit hf,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w;
    logic [3:0]  c;
    int k, x;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 8; i++) begin
        w = ((h == 1) != hf) ? b : a;
        k = hf ? 7 - i : i;
        c = prom_m[{p, w[31-4*k -: 4]}];
        x = int'(x0) + 8 * h + i;
        if (c != 4'd0 && x < 256) exp_draw[(x - 6) & 255] = c;
      end
  endtask

  task automatic set_req(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                         input bit hf, input bit vf, input logic [3:0] ys,
                         input logic [31:0] a, input logic [31:0] b);
    logic [13:0] ea;
    code = c; xpos = x; pal = p; hflip = hf; vflip = vf; ysub = ys; w0 = a; w1 = b;
    ea = {c, ys ^ {4{vf}}, hf};
    aq.push_back(ea);
    ea[0] = ~ea[0];
    aq.push_back(ea);
  endtask

  // accept edge already issued; also tries a stray request mid-row that must be ignored
  task automatic finish_row(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                            input bit hf, input logic [31:0] a, input logic [31:0] b);
    int n;
    chk("busy_set", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      draw = (n == 3);
      if (n == 3) code = ~c;
      tick2(); n++;
    end
    draw = 1'b0;
    chk("row_time", 32'(n), 32'd18);
    model_draw(x, p, hf, a, b);
  endtask

  task automatic do_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                         input bit hf, input bit vf, input logic [3:0] ys,
                         input logic [31:0] a, input logic [31:0] b);
    set_req(c, x, p, hf, vf, ys, a, b);
    draw = 1'b1; tick2(); draw = 1'b0;
    finish_row(c, x, p, hf, a, b);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hinit_x = 1'b0; LHBL = 1'b1; hdump = 9'd0; draw = 1'b0; code = 9'd0;
    xpos = 8'd0; pal = 4'd0; hflip = 1'b0; vflip = 1'b0; ysub = 4'd0; prog_addr = 8'd0;
    prog_data = 4'd0; prog_en = 1'b0; rom_ok = 1'b1; w0 = 32'd0; w1 = 32'd0;
    for (int i = 0; i < 256; i++) begin exp_draw[i] = 4'd0; exp_play[i] = 4'd0; end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pxl", 32'(pxl), 32'd0);

    // palette p maps nibble n to (n + p) mod 16; palette 0 is identity
    for (int n = 0; n < 256; n++) begin
      prom_m[n] = 4'((n & 15) + (n >> 4));
      prog_addr = 8'(n); prog_data = prom_m[n]; prog_en = 1'b1;
      @(posedge clk); #1;
    end
    prog_en = 1'b0;

    play_line(1'b0); swap(); play_line(1'b0);

    // basic row, with one blanked slot that must neither show nor erase
    do_draw(9'h005, 8'd40, 4'd0, 1'b0, 1'b0, 4'd3, 32'h1234_5678, 32'h9ABC_DEF1);
    swap();
    hdump = 9'd35; LHBL = 1'b0; pq.push_back(4'd0); pchk = 1'b1;
    tick_pxl();
    pchk = 1'b0; LHBL = 1'b1;
    play_line(1'b1);

    do_draw(9'h005, 8'd40, 4'd0, 1'b1, 1'b1, 4'd3, 32'h1234_5678, 32'h9ABC_DEF1);
    swap(); play_line(1'b1);

    do_draw(9'h010, 8'd40, 4'd0, 1'b0, 1'b0, 4'd0, 32'h3333_3333, 32'h3333_3333);
    do_draw(9'h011, 8'd44, 4'd0, 1'b0, 1'b0, 4'd1, 32'h0505_0505, 32'h0505_0505);
    swap(); play_line(1'b1);

    // right-edge clip; the next request rides on the line start that exposes it
    do_draw(9'h1FF, 8'd250, 4'd2, 1'b0, 1'b0, 4'd15, 32'h1234_5678, 32'h9ABC_DEF1);
    set_req(9'h020, 8'd0, 4'd1, 1'b0, 1'b1, 4'd0, 32'h1111_2222, 32'hFEDC_BA98);
    hinit_x = 1'b1; draw = 1'b1; tick2(); hinit_x = 1'b0; draw = 1'b0;
    model_swap();
    finish_row(9'h020, 8'd0, 4'd1, 1'b0, 32'h1111_2222, 32'hFEDC_BA98);
    play_line(1'b1);
    swap(); play_line(1'b1);

    // abort during the first half: pixels 0..2 land, pixel 3 is transparent either way
    code = 9'h0A0; xpos = 8'd100; pal = 4'd0; hflip = 1'b0; vflip = 1'b0; ysub = 4'd7;
    w0 = 32'h1230_5678; w1 = 32'h9ABC_DEF1;
    aq.push_back(14'h140E);
    draw = 1'b1; tick2(); draw = 1'b0;
    repeat (4) tick2();
    hinit_x = 1'b1; tick2(); hinit_x = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rom_cs", 32'(rom_cs), 32'd0);
    model_swap();
    exp_play[94] = 4'd1; exp_play[95] = 4'd2; exp_play[96] = 4'd3;
    repeat (30) tick2();
    chk("abort_no_refetch", 32'(aq.size()), 32'd0);
    play_line(1'b1);

    // reset while a fetch is stalled
    rom_ok = 1'b0;
    code = 9'h033; xpos = 8'd10; ysub = 4'd2;
    draw = 1'b1; tick2(); draw = 1'b0;
    tick2(); tick2();
    chk("stall_rom_cs", 32'(rom_cs), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
    chk("mid_rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pxl", 32'(pxl), 32'd0);
    rom_ok = 1'b1;
    do_draw(9'h033, 8'd10, 4'd0, 1'b0, 1'b0, 4'd2, 32'h1234_5678, 32'h9ABC_DEF1);

    repeat (8) @(posedge clk);
    chk("fetch_queue_empty", 32'(aq.size()), 32'd0);
    chk("pxl_queue_empty", 32'(pq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
